sumator_serial: RTL
===================

SUMATOR_SERIAL -- requirements
Module: sumator_serial

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled only while busy=0.
REQ-006 sub  input  1  mode: 0 = in0+in1+carry_in, 1 = in0+~in1+1.
REQ-007 carry_in  input  1  carry into bit 0 in add mode; ignored when sub=1.
REQ-008 in0  input  WIDTH  first operand.
REQ-009 in1  input  WIDTH  second operand.
REQ-010 out  output  WIDTH  result of the last completed operation.
REQ-011 carry_out  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-012 overflow  output  1  two's-complement overflow of the last completed operation.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM SHALL have states IDLE and RUN; busy SHALL equal (state==RUN).
REQ-016 IDLE: start=1 at a rising edge SHALL latch in0, in1, sub and effective carry (sub ? 1 : carry_in), clear chunk index to 0, and enter RUN.
REQ-017 RUN: each cycle SHALL add chunk [idx*CHUNK +: CHUNK] of latched operands (in1 inverted if sub) plus the running carry, store the sum chunk in an internal shadow register, and update the running carry.
REQ-018 The Nth RUN cycle (idx=N-1) SHALL copy the shadow result to out, set carry_out and overflow, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-019 Latency: done SHALL be high in the cycle following the Nth rising edge after the start-sampling edge; CHUNK=WIDTH (N=1) SHALL give done one cycle after start.
REQ-020 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 out, carry_out, overflow SHALL hold their values from the previous completion throughout RUN and IDLE until the next completion.
REQ-022 start while busy=1 SHALL be ignored; changes to in0, in1, sub and carry_in during RUN SHALL not affect the result.
REQ-023 start=1 in the cycle done=1 (state IDLE) SHALL be accepted, giving back-to-back operations with one result every N+1 cycles.
REQ-024 Result arithmetic SHALL be modulo 2^WIDTH; carry_out SHALL be the bit WIDTH of the full sum.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, idx 0, out 0, carry_out 0, overflow 0, busy 0, done 0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse and no update from the partial result.
REQ-027 After rst_n deasserts, the first start sampled SHALL begin a normal operation.

Verification (WIDTH=8, CHUNK=4 unless noted)
REQ-028 add: in1=0x99, in0=0x22, carry_in=0, start -> done after 2 cycles, out=0xBB, carry_out=0, overflow=0.
REQ-029 add with carry: 0x29+0x53, carry_in=1 -> out=0x7D, carry_out=0, overflow=0; then 0xC5+0x6D, carry_in=0 -> out=0x32, carry_out=1, overflow=0.
REQ-030 overflow: 0x85+0x95, carry_in=1 -> out=0x1B, carry_out=1, overflow=1; sub: in0=0x10, in1=0x20, sub=1 -> out=0xF0, carry_out=0, overflow=0.
REQ-031 protocol: start pulsed again and inputs changed mid-RUN -> ignored, original result reported, exactly one done pulse; start held high across done -> back-to-back results every 3 cycles.
REQ-032 reset mid-RUN: rst_n low after first chunk -> all outputs 0 at once, no done; subsequent op correct.
REQ-033 WIDTH=32, CHUNK=8: 0xFFFFFFFF+0x00000001 -> out=0, carry_out=1, overflow=0, done 4 cycles after start; CHUNK=32 -> done after 1 cycle with same result.

Source files
------------

// File: rtl/sumator_serial_if.sv
// Bus bundle for the chunk-serial adder/subtractor.
// The master drives operands and start; the slave returns the result and status.
interface sumator_serial_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             sub;
    logic             carry_in;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, carry_in, in0, in1,
        input  out, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, sub, carry_in, in0, in1,
        output out, carry_out, overflow, busy, done
    );
endinterface

// File: rtl/sumator_serial.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock over WIDTH/CHUNK cycles.
// Results are published only on completion, so out holds its value during RUN.
module sumator_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    sumator_serial_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] result;
    logic             sub_q;
    logic             carry;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   sum_c;
    logic             msb_cin;
    logic             accept;
    logic             last;
    int               base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN:  if (last) state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        accept   = (state == IDLE) && bus.start;
        last     = (state == RUN) && (idx == IW'(N - 1));
    end

    // One chunk of the ripple per cycle; b is inverted in subtract mode.
    always_comb begin
        base    = int'(idx) * CHUNK;
        a_c     = a_q[base +: CHUNK];
        b_c     = b_q[base +: CHUNK] ^ {CHUNK{sub_q}};
        sum_c   = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
        msb_cin = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
        result  = shadow;
        result[base +: CHUNK] = sum_c[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            shadow        <= '0;
            sub_q         <= 1'b0;
            carry         <= 1'b0;
            bus.out       <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= last;
            if (accept) begin
                a_q   <= bus.in0;
                b_q   <= bus.in1;
                sub_q <= bus.sub;
                carry <= bus.sub | bus.carry_in;
                idx   <= '0;
            end else if (state == RUN) begin
                shadow[base +: CHUNK] <= sum_c[CHUNK-1:0];
                carry <= sum_c[CHUNK];
                idx   <= idx + 1'b1;
                if (last) begin
                    idx           <= '0;
                    bus.out       <= result;
                    bus.carry_out <= sum_c[CHUNK];
                    bus.overflow  <= msb_cin ^ sum_c[CHUNK];
                end
            end
        end
    end
endmodule
